// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers raster position from a pair of active-high sync inputs and decides
// whether the incoming timing matches the expected line/frame geometry.
//
//   hpos        clocks since the last hsync rising edge (saturates at 2047)
//   vpos        lines since the last frame boundary (saturates at 2047)
//   line_len    length in clocks of the last completed line
//   frame_lines line count of the last completed frame
//   frame_start one-cycle pulse the cycle after a frame boundary
//   locked      high while the timing has been verified as stable
//   sync_err    one-cycle pulse when an established lock is lost
//
// Ports:
//   clk25m      in   pixel clock, everything runs on its rising edge
//   rst         in   synchronous active-high reset
//   hsync_in    in   horizontal sync, active-high, synchronous to clk25m
//   vsync_in    in   vertical sync, active-high, synchronous to clk25m
//   hpos        out  [10:0]
//   vpos        out  [10:0]
//   line_len    out  [10:0]
//   frame_lines out  [10:0]
//   frame_start out
//   locked      out
//   sync_err    out
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_TOTAL     = 1057,
    parameter int V_TOTAL     = 629,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk25m,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [10:0] hpos,
    output logic [10:0] vpos,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    localparam logic [10:0] POS_MAX   = 11'd2047;
    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam int          CNT_W     = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);
    // good_cnt value that, once incremented, reaches LOCK_FRAMES
    localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(LOCK_FRAMES - 1);

    lock_state_t      state_reg;
    logic [CNT_W-1:0] good_cnt_reg;
    logic             hs_d_reg;
    logic             vs_d_reg;
    logic             h_seen_reg;     // a line start has been observed since reset
    logic             v_pend_reg;     // vsync rose, waiting for the next hsync rise
    logic             f_seen_reg;     // a frame boundary has been observed since reset
    logic             frame_ok_reg;   // no bad line so far in the current frame

    logic        hrise;
    logic        vrise;
    logic        frame_edge;
    logic        line_chk;
    logic        timeout;
    logic        bad_line;
    logic        count_ok;
    logic        frame_good;
    logic [10:0] hpos_inc;
    logic [10:0] vpos_inc;

    assign hrise = hsync_in & ~hs_d_reg;
    assign vrise = vsync_in & ~vs_d_reg;

    // A vsync rise in the same cycle as an hsync rise starts the frame right
    // away; otherwise the pending flag holds it until the next line start.
    assign frame_edge = hrise & (v_pend_reg | vrise);

    // Saturating increments. They double as the "length" of the line/frame
    // that just ended, so an overlong line reports 2047 rather than wrapping.
    assign hpos_inc = (hpos == POS_MAX) ? POS_MAX : hpos + 11'd1;
    assign vpos_inc = (vpos == POS_MAX) ? POS_MAX : vpos + 11'd1;

    // The very first line start after reset has no measured predecessor.
    assign line_chk = hrise & h_seen_reg;

    // hpos only equals H_TOTAL if the expected line start failed to show up
    // in time; an hsync rise arriving exactly now is already one clock late.
    assign timeout = h_seen_reg & (hpos == H_TOTAL_L);

    assign bad_line   = (line_chk & (hpos_inc != H_TOTAL_L)) | timeout;
    assign count_ok   = (vpos_inc == V_TOTAL_L);
    assign frame_good = frame_ok_reg & ~bad_line & count_ok;

    always_ff @(posedge clk25m) begin
        if (rst) begin
            hs_d_reg     <= 1'b0;
            vs_d_reg     <= 1'b0;
            hpos         <= '0;
            vpos         <= '0;
            line_len     <= '0;
            frame_lines  <= '0;
            frame_start  <= 1'b0;
            sync_err     <= 1'b0;
            locked       <= 1'b0;
            h_seen_reg   <= 1'b0;
            v_pend_reg   <= 1'b0;
            f_seen_reg   <= 1'b0;
            frame_ok_reg <= 1'b0;
            good_cnt_reg <= '0;
            state_reg    <= SEARCH;
        end else begin
            hs_d_reg    <= hsync_in;
            vs_d_reg    <= vsync_in;
            frame_start <= frame_edge;
            sync_err    <= 1'b0;

            // Horizontal position and line length
            if (hrise) begin
                hpos       <= '0;
                h_seen_reg <= 1'b1;
                if (h_seen_reg) begin
                    line_len <= hpos_inc;
                end
            end else begin
                hpos <= hpos_inc;
            end

            // Vertical position and frame length
            if (frame_edge) begin
                vpos       <= '0;
                v_pend_reg <= 1'b0;
                f_seen_reg <= 1'b1;
                if (f_seen_reg) begin
                    frame_lines <= vpos_inc;
                end
            end else begin
                if (vrise) begin
                    v_pend_reg <= 1'b1;
                end
                if (hrise) begin
                    vpos <= vpos_inc;
                end
            end

            // A bad line on the boundary belongs to the frame that is ending,
            // so the new frame always starts clean.
            if (frame_edge) begin
                frame_ok_reg <= 1'b1;
            end else if (bad_line) begin
                frame_ok_reg <= 1'b0;
            end

            // Lock tracking
            case (state_reg)
                SEARCH: begin
                    if (frame_edge) begin
                        state_reg    <= VERIFY;
                        good_cnt_reg <= '0;
                    end
                end
                VERIFY: begin
                    if (bad_line) begin
                        state_reg <= SEARCH;
                    end else if (frame_edge) begin
                        if (frame_good) begin
                            good_cnt_reg <= good_cnt_reg + CNT_W'(1);
                            if (good_cnt_reg == GOOD_LAST) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                            end
                        end else begin
                            state_reg <= SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    if (bad_line || (frame_edge && !count_ok)) begin
                        state_reg <= SEARCH;
                        locked    <= 1'b0;
                        sync_err  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= SEARCH;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder using a shrunken raster (40 clocks per
// line, 12 lines per frame) so whole frames fit in a short run. Inputs are
// driven on the falling edge; outputs are read on the falling edge as well.
// A passive monitor records values at every frame_start / sync_err pulse.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

    localparam int HT    = 40;   // clocks per line
    localparam int VT    = 12;   // lines per frame
    localparam int HS_W  = 8;    // hsync high time in clocks
    localparam int VS_L  = 2;    // vsync high time in lines
    localparam int LOCKF = 2;

    logic        clk25m   = 1'b0;
    logic        rst      = 1'b1;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [10:0] hpos;
    logic [10:0] vpos;
    logic [10:0] line_len;
    logic [10:0] frame_lines;
    logic        frame_start;
    logic        locked;
    logic        sync_err;

    int n_checks = 0;
    int n_errors = 0;

    vga_sync_decoder #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .LOCK_FRAMES (LOCKF)
    ) dut (
        .clk25m      (clk25m),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hpos        (hpos),
        .vpos        (vpos),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .frame_start (frame_start),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #20 clk25m = ~clk25m;

    // ---------------- monitor ----------------
    int          fs_cnt     = 0;
    int          se_cnt     = 0;
    int          se_cycles  = 0;
    int          lk_cycles  = 0;
    logic        se_prev    = 1'b0;
    logic [10:0] hpos_prev  = '0;
    logic [10:0] se_hpos    = '0;
    logic        se_locked  = 1'b0;
    logic [10:0] cap_vpos   [64];
    logic [10:0] cap_flines [64];
    logic [10:0] cap_llen   [64];
    logic [10:0] cap_hpos   [64];
    logic        cap_locked [64];

    always @(negedge clk25m) begin
        if (frame_start) begin
            if (fs_cnt < 64) begin
                cap_vpos[fs_cnt]   = vpos;
                cap_flines[fs_cnt] = frame_lines;
                cap_llen[fs_cnt]   = line_len;
                cap_hpos[fs_cnt]   = hpos;
                cap_locked[fs_cnt] = locked;
            end
            fs_cnt++;
        end
        if (sync_err) begin
            se_cycles++;
            se_hpos   = hpos_prev;
            se_locked = locked;
            if (!se_prev) se_cnt++;
        end
        if (locked) lk_cycles++;
        se_prev   = sync_err;
        hpos_prev = hpos;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("check %s: ok (%0d)", tag, got);
        end
    endtask

    // One clock with the given sync levels; returns on the following falling
    // edge so the outputs then reflect this cycle's inputs.
    task automatic cyc(input logic h, input logic v);
        hsync_in = h;
        vsync_in = v;
        @(negedge clk25m);
    endtask

    task automatic run_line(input int len, input logic v, input int start);
        for (int i = start; i < len; i++) cyc(i < HS_W, v);
    endtask

    task automatic run_frame(input int nlines, input int long_idx);
        for (int l = 0; l < nlines; l++)
            run_line((l == long_idx) ? HT + 1 : HT, l < VS_L, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hpos"},        hpos,        0);
        check({tag, "_vpos"},        vpos,        0);
        check({tag, "_line_len"},    line_len,    0);
        check({tag, "_frame_lines"}, frame_lines, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_locked"},      locked,      0);
        check({tag, "_sync_err"},    sync_err,    0);
    endtask

    // ---------------- stimulus ----------------
    int se0;
    int sc0;
    int lk0;
    int fs0;

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (4) @(negedge clk25m);
        check_all_zero("reset");
        rst = 1'b0;

        // Ideal timing: lock after the third frame boundary
        for (int f = 0; f < 4; f++) run_frame(VT, -1);
        check("b0_vpos",          cap_vpos[0],   0);
        check("b0_frame_lines",   cap_flines[0], 0);
        check("b0_line_len",      cap_llen[0],   0);
        check("b1_frame_lines",   cap_flines[1], VT);
        check("b1_line_len",      cap_llen[1],   HT);
        check("b1_locked",        cap_locked[1], 0);
        check("b2_locked",        cap_locked[2], 1);
        check("b2_hpos",          cap_hpos[2],   0);
        check("ideal_fs_count",   fs_cnt,        4);
        check("ideal_locked",     locked,        1);
        check("ideal_line_len",   line_len,      HT);
        check("ideal_hpos_end",   hpos,          HT - 1);
        check("ideal_vpos_end",   vpos,          VT - 1);
        check("ideal_no_syncerr", se_cnt,        0);

        // One overlong line while locked
        se0 = se_cnt;
        sc0 = se_cycles;
        run_frame(VT, 5);
        check("long_syncerr_pulses", se_cnt - se0,    1);
        check("long_syncerr_width",  se_cycles - sc0, 1);
        check("long_timeout_hpos",   se_hpos,         HT);
        check("long_locked_at_err",  se_locked,       0);
        check("long_locked_after",   locked,          0);

        // Frames one line too long never lock
        se0 = se_cnt;
        lk0 = lk_cycles;
        for (int f = 0; f < 4; f++) run_frame(VT + 1, -1);
        check("vlong_frame_lines", frame_lines,     VT + 1);
        check("vlong_never_lock",  lk_cycles - lk0, 0);
        check("vlong_no_syncerr",  se_cnt - se0,    0);

        // vsync and hsync rising together, then vsync rising mid-line
        fs0 = fs_cnt;
        cyc(1'b1, 1'b1);
        check("same_vpos",        vpos,        0);
        check("same_fs_on",       frame_start, 1);
        cyc(1'b1, 1'b1);
        check("same_fs_single",   frame_start, 0);
        run_line(HT, 1'b1, 2);
        cyc(1'b1, 1'b1);
        check("same_next_vpos",   vpos,        1);
        check("same_next_fs",     frame_start, 0);
        run_line(HT, 1'b1, 1);
        for (int l = 2; l < VT - 1; l++) run_line(HT, 1'b0, 0);
        for (int i = 0; i < 20; i++) cyc(i < HS_W, 1'b0);
        cyc(1'b0, 1'b1);
        check("pend_vpos_held",   vpos,        VT - 1);
        check("pend_no_fs",       frame_start, 0);
        for (int i = 21; i < HT; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        check("pend_vpos",        vpos,        0);
        check("pend_fs",          frame_start, 1);
        check("pend_frame_lines", frame_lines, VT);
        run_line(HT, 1'b1, 1);
        for (int l = 1; l < VT; l++) run_line(HT, l < VS_L, 0);
        check("edge_fs_count",    fs_cnt - fs0, 2);

        // hsync held low: hpos saturates, no sync_err outside LOCKED
        repeat (2200) cyc(1'b0, 1'b0);
        check("sat_hpos_mid",  hpos, 2047);
        repeat (800) cyc(1'b0, 1'b0);
        check("sat_hpos_end",  hpos, 2047);
        check("sat_no_syncerr", se_cnt - se0, 0);

        // Relock, then reset while locked
        for (int f = 0; f < 4; f++) run_frame(VT, -1);
        check("relock_locked", locked, 1);
        se0 = se_cnt;
        for (int l = 0; l < 5; l++) run_line(HT, l < VS_L, 0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        check_all_zero("rst_locked");
        rst = 1'b0;
        run_line(HT, 1'b0, 1);
        for (int l = 6; l < VT; l++) run_line(HT, 1'b0, 0);
        fs0 = fs_cnt;
        for (int f = 0; f < 3; f++) run_frame(VT, -1);
        check("rst_r0_frame_lines", cap_flines[fs0],     0);
        check("rst_r0_locked",      cap_locked[fs0],     0);
        check("rst_r1_locked",      cap_locked[fs0 + 1], 0);
        check("rst_r2_locked",      cap_locked[fs0 + 2], 1);
        check("rst_fs_count",       fs_cnt - fs0,        3);
        check("rst_no_syncerr",     se_cnt - se0,        0);
        check("rst_locked_end",     locked,              1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
